// File: rtl/accumulator_pkg.sv
// Shared opcode definitions for the accumulator bank and its op unit.
package accumulator_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_HOLD = 3'b000;
  localparam logic [OP_W-1:0] OP_CLR  = 3'b001;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b010;
  localparam logic [OP_W-1:0] OP_SHR  = 3'b011;
  localparam logic [OP_W-1:0] OP_ROL  = 3'b100;
  localparam logic [OP_W-1:0] OP_ROR  = 3'b101;
  localparam logic [OP_W-1:0] OP_INC  = 3'b110;
  localparam logic [OP_W-1:0] OP_DEC  = 3'b111;

endpackage

// File: rtl/acc_op_unit.sv
// Combinational in-place operation on one register value.
// Shifts and rotates are written with shift operators so that WIDTH=1
// naturally yields 0 for SHL/SHR and an unchanged value for ROL/ROR.
module acc_op_unit
  import accumulator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic [OP_W-1:0]  op,
  input  logic             carry_in,
  output logic [WIDTH-1:0] next_value,
  output logic             next_carry,
  output logic             carry_update
);

  // Compute the new register value and the carry it produces for the given op
  always_comb begin
    next_value   = value;
    next_carry   = carry_in;
    carry_update = 1'b0;
    case (op)
      OP_CLR: begin
        next_value   = '0;
        next_carry   = 1'b0;
        carry_update = 1'b1;
      end
      OP_SHL: begin
        next_value   = value << 1;
        next_carry   = value[WIDTH-1];
        carry_update = 1'b1;
      end
      OP_SHR: begin
        next_value   = value >> 1;
        next_carry   = value[0];
        carry_update = 1'b1;
      end
      OP_ROL: begin
        next_value   = (value << 1) | (value >> (WIDTH - 1));
        next_carry   = value[WIDTH-1];
        carry_update = 1'b1;
      end
      OP_ROR: begin
        next_value   = (value >> 1) | (value << (WIDTH - 1));
        next_carry   = value[0];
        carry_update = 1'b1;
      end
      OP_INC: begin
        next_value   = value + 1'b1;
        next_carry   = &value;
        carry_update = 1'b1;
      end
      OP_DEC: begin
        next_value   = value - 1'b1;
        next_carry   = ~|value;
        carry_update = 1'b1;
      end
      default: begin
        next_value   = value;
        next_carry   = carry_in;
        carry_update = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/accumulator_bank.sv
// Bank of NUM_REGS accumulators between the W bus and the ALU.
// One register (wr_sel) is loaded or operated on per edge; rd_sel picks the
// register seen on the ALU operand and, when ea is high, on the W bus.
// The carry flag is a single flop shared by all registers.
module accumulator_bank
  import accumulator_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = $clog2(NUM_REGS > 1 ? NUM_REGS : 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             la_n,
  input  logic [OP_W-1:0]  op,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic             ea,
  input  logic [WIDTH-1:0] w_bus_in,
  output logic [WIDTH-1:0] w_bus_out,
  output logic [WIDTH-1:0] alu,
  output logic             carry,
  output logic             zero,
  output logic             neg
);

  logic [WIDTH-1:0] regs [NUM_REGS];
  logic             carry_q;
  logic             wr_valid;
  logic [WIDTH-1:0] wr_value;
  logic [WIDTH-1:0] rd_value;
  logic [WIDTH-1:0] op_value;
  logic             op_carry;
  logic             op_carry_update;

  // Decode the write target; out-of-range selects leave wr_valid low
  always_comb begin
    wr_valid = 1'b0;
    wr_value = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_sel == SEL_W'(i)) begin
        wr_valid = 1'b1;
        wr_value = regs[i];
      end
    end
  end

  // Read mux; an out-of-range rd_sel reads as zero
  always_comb begin
    rd_value = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_value = regs[i];
      end
    end
  end

  acc_op_unit #(
    .WIDTH(WIDTH)
  ) u_op (
    .value       (wr_value),
    .op          (op),
    .carry_in    (carry_q),
    .next_value  (op_value),
    .next_carry  (op_carry),
    .carry_update(op_carry_update)
  );

  // Register array: load from the bus has priority over the in-place op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel == SEL_W'(i)) begin
          if (!la_n) begin
            regs[i] <= w_bus_in;
          end else begin
            regs[i] <= op_value;
          end
        end
      end
    end
  end

  // Shared carry flop: cleared by a load, updated by ops that define a carry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
    end else if (wr_valid) begin
      if (!la_n) begin
        carry_q <= 1'b0;
      end else if (op_carry_update) begin
        carry_q <= op_carry;
      end
    end
  end

  assign alu       = rd_value;
  assign w_bus_out = ea ? rd_value : {WIDTH{1'bz}};
  assign carry     = carry_q;
  assign zero      = (rd_value == '0);
  assign neg       = rd_value[WIDTH-1];

endmodule

// File: tb/tb_accumulator_bank.sv
// Directed bench for accumulator_bank: a default 8x4 instance driven from a
// vector table, an 8x3 instance for out-of-range selects, and a 16x8 instance.
module tb_accumulator_bank;
  import accumulator_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   tests    = 0;
  int   failures = 0;

  // Free-running clock, rising edge active
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, NUM_REGS=4
  logic       a_la_n;
  logic [2:0] a_op;
  logic [1:0] a_wr_sel;
  logic [1:0] a_rd_sel;
  logic       a_ea;
  logic [7:0] a_din;
  wire  [7:0] a_bus;
  logic [7:0] a_alu;
  logic       a_carry;
  logic       a_zero;
  logic       a_neg;
  logic       a_drive_en;

  // The bench drives a marker onto the bus whenever the DUT should release it
  assign a_bus = a_drive_en ? 8'h5A : 8'hzz;

  accumulator_bank #(.WIDTH(8), .NUM_REGS(4)) dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .la_n     (a_la_n),
    .op       (a_op),
    .wr_sel   (a_wr_sel),
    .rd_sel   (a_rd_sel),
    .ea       (a_ea),
    .w_bus_in (a_din),
    .w_bus_out(a_bus),
    .alu      (a_alu),
    .carry    (a_carry),
    .zero     (a_zero),
    .neg      (a_neg)
  );

  // Instance B: WIDTH=8, NUM_REGS=3
  logic       b_la_n;
  logic [2:0] b_op;
  logic [1:0] b_wr_sel;
  logic [1:0] b_rd_sel;
  logic [7:0] b_din;
  logic [7:0] b_bus;
  logic [7:0] b_alu;
  logic       b_carry;
  logic       b_zero;
  logic       b_neg;

  accumulator_bank #(.WIDTH(8), .NUM_REGS(3)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .la_n     (b_la_n),
    .op       (b_op),
    .wr_sel   (b_wr_sel),
    .rd_sel   (b_rd_sel),
    .ea       (1'b1),
    .w_bus_in (b_din),
    .w_bus_out(b_bus),
    .alu      (b_alu),
    .carry    (b_carry),
    .zero     (b_zero),
    .neg      (b_neg)
  );

  // Instance C: WIDTH=16, NUM_REGS=8
  logic        c_la_n;
  logic [2:0]  c_op;
  logic [2:0]  c_wr_sel;
  logic [2:0]  c_rd_sel;
  logic [15:0] c_din;
  logic [15:0] c_bus;
  logic [15:0] c_alu;
  logic        c_carry;
  logic        c_zero;
  logic        c_neg;

  accumulator_bank #(.WIDTH(16), .NUM_REGS(8)) dut_c (
    .clk      (clk),
    .rst_n    (rst_n),
    .la_n     (c_la_n),
    .op       (c_op),
    .wr_sel   (c_wr_sel),
    .rd_sel   (c_rd_sel),
    .ea       (1'b1),
    .w_bus_in (c_din),
    .w_bus_out(c_bus),
    .alu      (c_alu),
    .carry    (c_carry),
    .zero     (c_zero),
    .neg      (c_neg)
  );

  typedef struct {
    logic       la_n;
    logic [2:0] op;
    logic [1:0] wr_sel;
    logic [1:0] rd_sel;
    logic       ea;
    logic [7:0] din;
    logic [7:0] exp_alu;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic la_n, input logic [2:0] op,
                                 input logic [1:0] wr_sel, input logic [1:0] rd_sel,
                                 input logic ea, input logic [7:0] din,
                                 input logic [7:0] exp_alu, input logic exp_carry);
    vec_t v;
    v.la_n      = la_n;
    v.op        = op;
    v.wr_sel    = wr_sel;
    v.rd_sel    = rd_sel;
    v.ea        = ea;
    v.din       = din;
    v.exp_alu   = exp_alu;
    v.exp_carry = exp_carry;
    vecs.push_back(v);
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Full output check of instance A against an expected register value
  task automatic checkA(input string name, input logic [7:0] exp_alu, input logic exp_carry);
    checkOutput({name, " alu"},   16'(a_alu), 16'(exp_alu));
    checkOutput({name, " carry"}, 16'(a_carry), 16'(exp_carry));
    checkOutput({name, " zero"},  16'(a_zero), 16'(exp_alu == 8'h00));
    checkOutput({name, " neg"},   16'(a_neg), 16'(exp_alu[7]));
    checkOutput({name, " bus"},   16'(a_bus), 16'(a_ea ? exp_alu : 8'h5A));
  endtask

  // Drive instance A between edges, then sample just after the next edge
  task automatic applyStimulus(input logic la_n, input logic [2:0] op,
                               input logic [1:0] wr_sel, input logic [1:0] rd_sel,
                               input logic ea, input logic [7:0] din);
    @(negedge clk);
    a_la_n     = la_n;
    a_op       = op;
    a_wr_sel   = wr_sel;
    a_rd_sel   = rd_sel;
    a_ea       = ea;
    a_din      = din;
    a_drive_en = !ea;
    @(posedge clk);
    #1;
  endtask

  task automatic stepB(input logic la_n, input logic [2:0] op,
                       input logic [1:0] wr_sel, input logic [1:0] rd_sel, input logic [7:0] din);
    @(negedge clk);
    b_la_n   = la_n;
    b_op     = op;
    b_wr_sel = wr_sel;
    b_rd_sel = rd_sel;
    b_din    = din;
    @(posedge clk);
    #1;
  endtask

  task automatic stepC(input logic la_n, input logic [2:0] op,
                       input logic [2:0] wr_sel, input logic [2:0] rd_sel, input logic [15:0] din);
    @(negedge clk);
    c_la_n   = la_n;
    c_op     = op;
    c_wr_sel = wr_sel;
    c_rd_sel = rd_sel;
    c_din    = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    a_la_n     = 1'b1; a_op = OP_HOLD; a_wr_sel = 2'd0; a_rd_sel = 2'd0;
    a_ea       = 1'b0; a_din = 8'h00; a_drive_en = 1'b1;
    b_la_n     = 1'b1; b_op = OP_HOLD; b_wr_sel = 2'd0; b_rd_sel = 2'd0; b_din = 8'h00;
    c_la_n     = 1'b1; c_op = OP_HOLD; c_wr_sel = 3'd0; c_rd_sel = 3'd0; c_din = 16'h0000;

    #12;
    checkA("reset", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load reg1, then reset asynchronously between edges with an INC pending
    applyStimulus(1'b0, OP_HOLD, 2'd1, 2'd1, 1'b1, 8'hA5);
    checkA("load r1", 8'hA5, 1'b0);
    @(negedge clk);
    a_la_n = 1'b1; a_op = OP_INC; a_wr_sel = 2'd1; a_rd_sel = 2'd1;
    a_ea = 1'b0; a_drive_en = 1'b1;
    #2 rst_n = 1'b0;
    #1 checkA("async reset", 8'h00, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 checkA("first edge after reset", 8'h01, 1'b0);

    // Same-cycle read of the register being loaded returns the old value
    @(negedge clk);
    a_la_n = 1'b0; a_op = OP_HOLD; a_wr_sel = 2'd2; a_rd_sel = 2'd2;
    a_ea = 1'b1; a_drive_en = 1'b0; a_din = 8'h3C;
    #1 checkA("no bypass", 8'h00, 1'b0);
    @(posedge clk);
    #1 checkA("load r2", 8'h3C, 1'b0);

    // State here: r0=00 r1=01 r2=3C r3=00 carry=0
    addVec(1'b0, OP_HOLD, 2'd1, 2'd1, 1'b1, 8'h81, 8'h81, 1'b0);
    addVec(1'b1, OP_SHL,  2'd1, 2'd1, 1'b1, 8'h00, 8'h02, 1'b1);
    addVec(1'b0, OP_HOLD, 2'd1, 2'd1, 1'b1, 8'h81, 8'h81, 1'b0);
    addVec(1'b1, OP_SHR,  2'd1, 2'd1, 1'b1, 8'h00, 8'h40, 1'b1);
    addVec(1'b0, OP_HOLD, 2'd1, 2'd1, 1'b1, 8'h81, 8'h81, 1'b0);
    addVec(1'b1, OP_ROL,  2'd1, 2'd1, 1'b1, 8'h00, 8'h03, 1'b1);
    addVec(1'b0, OP_HOLD, 2'd1, 2'd1, 1'b1, 8'h01, 8'h01, 1'b0);
    addVec(1'b1, OP_ROR,  2'd1, 2'd1, 1'b0, 8'h00, 8'h80, 1'b1);
    addVec(1'b0, OP_HOLD, 2'd3, 2'd3, 1'b1, 8'hFF, 8'hFF, 1'b0);
    addVec(1'b1, OP_INC,  2'd3, 2'd3, 1'b1, 8'h00, 8'h00, 1'b1);
    addVec(1'b1, OP_DEC,  2'd3, 2'd3, 1'b1, 8'h00, 8'hFF, 1'b1);
    addVec(1'b0, OP_HOLD, 2'd3, 2'd3, 1'b1, 8'h10, 8'h10, 1'b0);
    addVec(1'b1, OP_INC,  2'd3, 2'd3, 1'b1, 8'h00, 8'h11, 1'b0);
    addVec(1'b0, OP_INC,  2'd0, 2'd0, 1'b1, 8'h55, 8'h55, 1'b0);
    addVec(1'b1, OP_CLR,  2'd0, 2'd0, 1'b1, 8'h00, 8'h00, 1'b0);
    addVec(1'b1, OP_DEC,  2'd0, 2'd0, 1'b1, 8'h00, 8'hFF, 1'b1);
    addVec(1'b1, OP_HOLD, 2'd0, 2'd1, 1'b1, 8'h00, 8'h80, 1'b1);
    addVec(1'b1, OP_HOLD, 2'd0, 2'd2, 1'b1, 8'h00, 8'h3C, 1'b1);
    addVec(1'b1, OP_HOLD, 2'd0, 2'd3, 1'b0, 8'h00, 8'h11, 1'b1);
    addVec(1'b1, OP_ROR,  2'd2, 2'd2, 1'b1, 8'h00, 8'h1E, 1'b0);
    addVec(1'b1, OP_ROL,  2'd1, 2'd3, 1'b1, 8'h00, 8'h11, 1'b1);
    addVec(1'b1, OP_HOLD, 2'd1, 2'd1, 1'b1, 8'h00, 8'h01, 1'b1);
    addVec(1'b1, OP_CLR,  2'd1, 2'd0, 1'b1, 8'h00, 8'hFF, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].la_n, vecs[i].op, vecs[i].wr_sel, vecs[i].rd_sel,
                    vecs[i].ea, vecs[i].din);
      checkA($sformatf("vec%0d", i), vecs[i].exp_alu, vecs[i].exp_carry);
    end

    // rd_sel changes propagate to alu/zero/neg without waiting for an edge
    @(negedge clk);
    a_op = OP_HOLD; a_rd_sel = 2'd1;
    #1 checkA("rd_sel r1 comb", 8'h00, 1'b0);
    a_rd_sel = 2'd0;
    #1 checkA("rd_sel r0 comb", 8'hFF, 1'b0);

    // Instance B: writes to a non-existent register change nothing
    stepB(1'b0, OP_HOLD, 2'd0, 2'd0, 8'h77);
    checkOutput("B load r0", 16'(b_alu), 16'h0077);
    stepB(1'b0, OP_HOLD, 2'd1, 2'd1, 8'hFF);
    stepB(1'b1, OP_INC,  2'd1, 2'd1, 8'h00);
    checkOutput("B inc wrap alu",   16'(b_alu), 16'h0000);
    checkOutput("B inc wrap carry", 16'(b_carry), 16'h0001);
    stepB(1'b0, OP_HOLD, 2'd3, 2'd3, 8'h99);
    checkOutput("B rd3 alu",   16'(b_alu), 16'h0000);
    checkOutput("B rd3 zero",  16'(b_zero), 16'h0001);
    checkOutput("B wr3 carry", 16'(b_carry), 16'h0001);
    stepB(1'b1, OP_CLR,  2'd3, 2'd0, 8'h00);
    checkOutput("B r0 kept",     16'(b_alu), 16'h0077);
    checkOutput("B r0 bus",      16'(b_bus), 16'h0077);
    checkOutput("B clr3 carry",  16'(b_carry), 16'h0001);
    stepB(1'b1, OP_HOLD, 2'd3, 2'd2, 8'h00);
    checkOutput("B r2 kept", 16'(b_alu), 16'h0000);

    // Instance C: independent load/readback of all eight 16-bit registers
    for (int i = 0; i < 8; i++) begin
      stepC(1'b0, OP_HOLD, 3'(i), 3'(i), 16'hA000 + 16'(i) * 16'h0101);
    end
    for (int i = 7; i >= 0; i--) begin
      stepC(1'b1, OP_HOLD, 3'd0, 3'(i), 16'h0000);
      checkOutput($sformatf("C readback r%0d", i), c_alu, 16'hA000 + 16'(i) * 16'h0101);
    end
    stepC(1'b0, OP_HOLD, 3'd7, 3'd7, 16'hFFFF);
    checkOutput("C load FFFF neg", 16'(c_neg), 16'h0001);
    stepC(1'b1, OP_INC,  3'd7, 3'd7, 16'h0000);
    checkOutput("C inc wrap alu",   c_alu, 16'h0000);
    checkOutput("C inc wrap carry", 16'(c_carry), 16'h0001);
    checkOutput("C inc wrap zero",  16'(c_zero), 16'h0001);
    checkOutput("C inc wrap bus",   c_bus, 16'h0000);
    stepC(1'b1, OP_HOLD, 3'd7, 3'd6, 16'h0000);
    checkOutput("C r6 kept", c_alu, 16'hA606);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/accumulator_bank.md
Name: accumulator_bank

Overview:
- Parametrised successor to the single 8-bit accumulator: NUM_REGS registers of WIDTH bits each.
- Every register can be loaded from the W bus or driven back onto it.
- Adds in-place ops (clear, shift, rotate, increment, decrement), a carry flag, and zero/negative status.
- Sits between the W bus and the ALU; the selected register feeds the ALU operand input.

Parameters:
WIDTH, 8, data width of each register and of the bus.
NUM_REGS, 4, number of registers (>=1).
SEL_W, $clog2(NUM_REGS>1?NUM_REGS:2), width of the select fields (derived; not overridden).

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
la_n  input  1  active-low load: write w_bus_in into register wr_sel.
op  input  3  in-place operation on register wr_sel; used only when la_n=1.
wr_sel  input  SEL_W  target register for load/op.
rd_sel  input  SEL_W  register driven to w_bus_out and alu.
ea  input  1  active-high bus enable.
w_bus_in  input  WIDTH  data from W bus.
w_bus_out  output  WIDTH  reg[rd_sel] when ea=1, else all Z.
alu  output  WIDTH  reg[rd_sel], always driven.
carry  output  1  registered carry/borrow/shifted-out bit.
zero  output  1  combinational: alu == 0.
neg  output  1  combinational: alu[WIDTH-1].

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers = 0 and carry = 0 immediately.
  - Outputs: alu=0, zero=1, neg=0, w_bus_out follows ea (0 or Z).
  - Reset asserted mid-op discards that op; the first edge after release behaves as a normal cycle.
- Priority per edge:
  - la_n=0: reg[wr_sel] <= w_bus_in, carry <= 0. op is ignored.
  - else: apply op to reg[wr_sel]. Exactly one register changes per edge.
- op encodings (new value; carry):
  - 000 HOLD: unchanged; carry held.
  - 001 CLR: 0; carry <= 0.
  - 010 SHL: {r[W-2:0],0}; carry <= r[W-1].
  - 011 SHR (logical): {0,r[W-1:1]}; carry <= r[0].
  - 100 ROL: {r[W-2:0],r[W-1]}; carry <= r[W-1].
  - 101 ROR: {r[0],r[W-1:1]}; carry <= r[0].
  - 110 INC: r+1 mod 2^W; carry <= 1 only on wrap from all-ones to 0.
  - 111 DEC: r-1 mod 2^W; carry <= 1 (borrow) only on wrap from 0 to all-ones.
- WIDTH=1: SHL/SHR yield 0 and ROL/ROR leave the value unchanged; carry rules still apply.
- wr_sel >= NUM_REGS: load/op ignored; no register and no carry update.
- rd_sel >= NUM_REGS: alu = 0.
- Latency:
  - Write is visible on alu/w_bus_out the cycle after the edge.
  - Same-cycle wr_sel==rd_sel returns the old value; there is no bypass.
- zero/neg are combinational from alu, so they track rd_sel changes with no latency.
- w_bus_out is tri-state, gated only by ea. Load with ea=1 on the same register is legal: the old value is driven and the register loads w_bus_in.
- Carry is a single shared flop. It is not per-register.

Decomposition:
- Package accumulator_pkg:
  - op code localparams: OP_HOLD, OP_CLR, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_INC, OP_DEC.
  - opcode width constant OP_W=3.
- Sub-module acc_op_unit, parametrised by WIDTH, purely combinational:
  - inputs: value, op, carry_in.
  - outputs: next_value, next_carry, carry_update enable.
- accumulator_bank holds the register array, carry flop, select/decode logic and output muxing.

Test Plan:
- Async reset: drive reg1=8'hA5, assert rst_n=0 between edges -> alu=0, carry=0, zero=1 immediately. With ea=0, w_bus_out=8'hZZ.
- Load/readback: la_n=0, wr_sel=2, w_bus_in=8'h3C, then rd_sel=2, ea=1 -> next cycle alu=w_bus_out=8'h3C, zero=0, neg=0. Same-cycle read of rd_sel=2 still shows the old 8'h00.
- Shifts/rotates on 8'h81:
  - SHL -> 8'h02, carry=1.
  - SHR from 8'h81 -> 8'h40, carry=1.
  - ROL from 8'h81 -> 8'h03, carry=1.
  - ROR from 8'h01 -> 8'h80, carry=1, neg=1.
- Wrap:
  - INC on 8'hFF -> 8'h00, carry=1, zero=1.
  - DEC on 8'h00 -> 8'hFF, carry=1, neg=1.
  - INC on 8'h10 -> 8'h11, carry=0.
- Priority/isolation:
  - la_n=0 with op=INC, w_bus_in=8'h55 -> reg=8'h55, carry=0.
  - Op on wr_sel=0 leaves regs 1..3 unchanged.
  - With NUM_REGS=3, wr_sel=3 write -> no change anywhere, alu reads 0 for rd_sel=3.
- Parameter sweep: WIDTH=16, NUM_REGS=8 -> INC on 16'hFFFF gives 16'h0000 with carry=1; all 8 registers load and read back independently.
